// File: rtl/wb_select_reg.sv
// Writeback select register: picks the writeback source, extracts big-endian
// loads, flags misaligned loads and registers everything for one cycle.
module wb_select_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        wbSel,
    input  logic [DATA_W-1:0] ALUresult,
    input  logic [DATA_W-1:0] DMresult,
    input  logic [DATA_W-1:0] linkAddr,
    input  logic [DATA_W-1:0] immUpper,
    input  logic [1:0]        memSize,
    input  logic              memSigned,
    input  logic [REG_AW-1:0] writeReg,
    input  logic              regWrite,
    output logic [DATA_W-1:0] data,
    output logic [REG_AW-1:0] wrReg,
    output logic              regWriteOut,
    output logic              validOut,
    output logic              align_err
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] shifted;
    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [31:0]       lane32;
    logic [DATA_W-1:0] word_ext;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] wb_val;
    logic              size_mis;
    logic              misaligned;

    logic [DATA_W-1:0] data_d, data_q;
    logic [REG_AW-1:0] wr_reg_d, wr_reg_q;
    logic              reg_write_d, reg_write_q;
    logic              valid_d, valid_q;
    logic              align_err_d, align_err_q;

    assign off = ALUresult[OFF_W-1:0];

    // Shifting left by the byte offset brings lane 'off' to the top, so every
    // size reads its lanes from the MSB end (big-endian order).
    assign shifted = DMresult << {off, 3'b000};
    assign lane8   = shifted[DATA_W-1 -: 8];
    assign lane16  = shifted[DATA_W-1 -: 16];
    assign lane32  = shifted[DATA_W-1 -: 32];

    // A word only needs extension when it is narrower than the datapath.
    if (DATA_W == 64) begin : g_word64
        assign word_ext = {{(DATA_W-32){memSigned & lane32[31]}}, lane32};
    end else begin : g_word32
        assign word_ext = DMresult;
    end

    // Load extraction and alignment check by access size.
    always_comb begin
        load_val = DMresult;
        size_mis = 1'b0;
        case (memSize)
            2'd0: load_val = {{(DATA_W-8){memSigned & lane8[7]}}, lane8};
            2'd1: begin
                load_val = {{(DATA_W-16){memSigned & lane16[15]}}, lane16};
                size_mis = off[0];
            end
            2'd2: begin
                load_val = word_ext;
                size_mis = (off[1:0] != 2'd0);
            end
            default: begin
                // dword on a 64-bit path; on a 32-bit path this is a word
                load_val = DMresult;
                if (DATA_W == 64) size_mis = (off != '0);
                else              size_mis = (off[1:0] != 2'd0);
            end
        endcase
    end

    assign misaligned = (wbSel == 2'd1) & size_mis;

    // Writeback source select, every encoding decoded.
    always_comb begin
        wb_val = ALUresult;
        case (wbSel)
            2'd0:    wb_val = ALUresult;
            2'd1:    wb_val = load_val;
            2'd2:    wb_val = linkAddr;
            default: wb_val = immUpper;
        endcase
    end

    // Next state: flush clears, stall holds, otherwise capture.
    always_comb begin
        data_d      = data_q;
        wr_reg_d    = wr_reg_q;
        reg_write_d = reg_write_q;
        valid_d     = valid_q;
        align_err_d = align_err_q;
        if (flush) begin
            data_d      = '0;
            wr_reg_d    = '0;
            reg_write_d = 1'b0;
            valid_d     = 1'b0;
            align_err_d = 1'b0;
        end else if (!stall) begin
            data_d      = misaligned ? '0 : wb_val;
            wr_reg_d    = writeReg;
            reg_write_d = in_valid & regWrite & (writeReg != '0) & ~misaligned;
            valid_d     = in_valid;
            align_err_d = in_valid & misaligned;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            wr_reg_q    <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            wr_reg_q    <= wr_reg_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_d;
        end
    end

    assign data        = data_q;
    assign wrReg       = wr_reg_q;
    assign regWriteOut = reg_write_q;
    assign validOut    = valid_q;
    assign align_err   = align_err_q;
endmodule

// File: tb/tb_wb_select_reg.sv
// Randomized + directed bench for wb_select_reg, 32- and 64-bit instances
// driven together and compared against a byte-level reference model.
module tb_wb_select_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, flush, in_valid, memSigned, regWrite;
    logic [1:0]  wbSel, memSize;
    logic [4:0]  writeReg;
    logic [63:0] alu, dm, link, imm;

    logic [31:0] d32;
    logic [4:0]  wr32;
    logic        rwo32, vo32, ae32;
    logic [63:0] d64;
    logic [4:0]  wr64;
    logic        rwo64, vo64, ae64;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  wr;
        logic        rwo, vo, ae;
    } exp_t;

    exp_t e32, e64, zero_e;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_select_reg #(.DATA_W(32), .REG_AW(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .wbSel(wbSel), .ALUresult(alu[31:0]), .DMresult(dm[31:0]), .linkAddr(link[31:0]),
        .immUpper(imm[31:0]), .memSize(memSize), .memSigned(memSigned), .writeReg(writeReg),
        .regWrite(regWrite), .data(d32), .wrReg(wr32), .regWriteOut(rwo32),
        .validOut(vo32), .align_err(ae32));

    wb_select_reg #(.DATA_W(64), .REG_AW(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .wbSel(wbSel), .ALUresult(alu), .DMresult(dm), .linkAddr(link),
        .immUpper(imm), .memSize(memSize), .memSigned(memSigned), .writeReg(writeReg),
        .regWrite(regWrite), .data(d64), .wrReg(wr64), .regWriteOut(rwo64),
        .validOut(vo64), .align_err(ae64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: pick bytes lane by lane from the top of the word.
    function automatic exp_t model(input int w);
        exp_t        r;
        logic [63:0] mask, dmw, ld, v;
        int          nb, off, n;
        logic        mis;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nb   = w / 8;
        off  = int'(alu[2:0]) % nb;
        case (memSize)
            2'd0:    n = 1;
            2'd1:    n = 2;
            2'd2:    n = 4;
            default: n = (w == 64) ? 8 : 4;
        endcase
        mis = (wbSel == 2'd1) && ((off % n) != 0);
        dmw = dm & mask;
        ld  = 64'd0;
        if (n == nb) ld = dmw;
        else begin
            for (int b = 0; b < n; b++) begin
                int         lane;
                logic [7:0] by;
                lane = off + b;
                by   = (lane < nb) ? 8'(dmw >> (w - 8 - 8 * lane)) : 8'd0;
                ld   = (ld << 8) | {56'd0, by};
            end
            if (memSigned && ld[8*n-1]) ld = ld | ~((64'd1 << (8 * n)) - 64'd1);
        end
        case (wbSel)
            2'd0:    v = alu;
            2'd1:    v = ld;
            2'd2:    v = link;
            default: v = imm;
        endcase
        if (mis) v = 64'd0;
        r.data = v & mask;
        r.wr   = writeReg;
        r.vo   = in_valid;
        r.rwo  = in_valid && regWrite && (writeReg != 5'd0) && !mis;
        r.ae   = in_valid && mis;
        return r;
    endfunction

    function automatic exp_t next_exp(input int w, input exp_t cur);
        if (flush)       return zero_e;
        else if (stall)  return cur;
        else             return model(w);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".d32"},   {32'd0, d32},  e32.data);
        chk({tag, ".wr32"},  {59'd0, wr32}, {59'd0, e32.wr});
        chk({tag, ".rwo32"}, {63'd0, rwo32}, {63'd0, e32.rwo});
        chk({tag, ".vo32"},  {63'd0, vo32}, {63'd0, e32.vo});
        chk({tag, ".ae32"},  {63'd0, ae32}, {63'd0, e32.ae});
        chk({tag, ".d64"},   d64,           e64.data);
        chk({tag, ".wr64"},  {59'd0, wr64}, {59'd0, e64.wr});
        chk({tag, ".rwo64"}, {63'd0, rwo64}, {63'd0, e64.rwo});
        chk({tag, ".vo64"},  {63'd0, vo64}, {63'd0, e64.vo});
        chk({tag, ".ae64"},  {63'd0, ae64}, {63'd0, e64.ae});
    endtask

    // One clock: predict from current inputs, take the edge, then compare.
    task automatic step(input string tag);
        exp_t n32, n64;
        n32 = next_exp(32, e32);
        n64 = next_exp(64, e64);
        @(posedge clk);
        if (rst_n) begin
            e32 = n32;
            e64 = n64;
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic v, input logic [1:0] sel, input logic [63:0] a,
                          input logic [63:0] d, input logic [1:0] sz, input logic sg,
                          input logic [4:0] wreg, input logic rw, input logic st, input logic fl);
        in_valid = v; wbSel = sel; alu = a; dm = d; memSize = sz; memSigned = sg;
        writeReg = wreg; regWrite = rw; stall = st; flush = fl;
    endtask

    task automatic rnd();
        in_valid  = ($urandom_range(7) != 0);
        wbSel     = 2'($urandom);
        alu       = {$urandom, $urandom};
        if ($urandom_range(1) == 1) alu[2:0] = 3'd0;
        dm        = {$urandom, $urandom};
        link      = {$urandom, $urandom};
        imm       = {$urandom, $urandom};
        memSize   = 2'($urandom);
        memSigned = 1'($urandom);
        writeReg  = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
        regWrite  = ($urandom_range(3) != 0);
        stall     = ($urandom_range(3) == 0);
        flush     = ($urandom_range(9) == 0);
    endtask

    initial begin
        zero_e = '{data: 64'd0, wr: 5'd0, rwo: 1'b0, vo: 1'b0, ae: 1'b0};
        e32 = zero_e;
        e64 = zero_e;
        link = 64'd0; imm = 64'd0;
        // An instruction presented while in reset must be discarded.
        set_in(1'b1, 2'd0, 64'h55, 64'd0, 2'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        #1 check_all("reset");
        step("reset_edge");
        #2 rst_n = 1'b1;

        // ALU path
        set_in(1'b1, 2'd0, 64'h00FF, 64'd0, 2'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        step("alu");
        chk("alu.data", {32'd0, d32}, 64'h0000_00FF);
        chk("alu.rwo", {63'd0, rwo32}, 64'd1);

        // Signed and unsigned byte at offset 1
        set_in(1'b1, 2'd1, 64'h1001_0001, 64'h12F4_5678, 2'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step("sbyte");
        chk("sbyte.data", {32'd0, d32}, 64'hFFFF_FFF4);
        memSigned = 1'b0;
        step("ubyte");
        chk("ubyte.data", {32'd0, d32}, 64'h0000_00F4);

        // Misaligned word: flag for one cycle only
        set_in(1'b1, 2'd1, 64'h1001_0006, 64'hDEAD_BEEF, 2'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step("misal");
        chk("misal.ae", {63'd0, ae32}, 64'd1);
        chk("misal.data", {32'd0, d32}, 64'd0);
        set_in(1'b1, 2'd0, 64'h1001_0006, 64'd0, 2'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step("misal_next");
        chk("misal_next.ae", {63'd0, ae32}, 64'd0);

        // Link to r0 then r31
        link = 64'h0040_0010;
        set_in(1'b1, 2'd2, 64'd0, 64'd0, 2'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("link_r0");
        chk("link_r0.rwo", {63'd0, rwo32}, 64'd0);
        chk("link_r0.data", {32'd0, d32}, 64'h0040_0010);
        writeReg = 5'd31;
        step("link_r31");
        chk("link_r31.rwo", {63'd0, rwo32}, 64'd1);

        // Stall holds three cycles, then flush overrides stall
        set_in(1'b1, 2'd0, 64'h1234, 64'd0, 2'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step("cap");
        for (int i = 0; i < 3; i++) begin
            rnd();
            stall = 1'b1; flush = 1'b0;
            step("stall");
            chk("stall.data", {32'd0, d32}, 64'h1234);
        end
        stall = 1'b1; flush = 1'b1;
        step("flush");
        chk("flush.vo", {63'd0, vo32}, 64'd0);

        // 64-bit byte at offset 5 (32-bit instance sees offset 1)
        set_in(1'b1, 2'd1, 64'h5, 64'h1122_3344_55F4_6677, 2'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        step("b64");
        chk("b64.data", d64, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("b64.d32", {32'd0, d32}, 64'hFFFF_FFF4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rnd();
            step("rand");
        end

        // Async reset between edges while valid
        set_in(1'b1, 2'd0, 64'hABCD, 64'd0, 2'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step("pre_rst");
        chk("pre_rst.vo", {63'd0, vo32}, 64'd1);
        #2 rst_n = 1'b0;
        e32 = zero_e;
        e64 = zero_e;
        #1 check_all("async_rst");
        step("in_rst");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rnd();
            step("post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_select_reg.md
WB_SELECT_REG -- requirements
Module: wb_select_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning register-file address width.
REQ-003 The block SHALL have localparam OFF_W = log2(DATA_W/8), meaning byte-offset bits taken from ALUresult.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 stall  in  1  hold all output registers.
REQ-007 flush  in  1  kill the instruction being captured.
REQ-008 in_valid  in  1  input instruction valid.
REQ-009 wbSel  in  2  writeback source: 0 ALUresult, 1 DMresult (extracted), 2 linkAddr, 3 immUpper.
REQ-010 ALUresult  in  DATA_W  ALU result; low OFF_W bits are the load byte offset.
REQ-011 DMresult  in  DATA_W  raw data-memory read word.
REQ-012 linkAddr  in  DATA_W  return address for jal/jalr.
REQ-013 immUpper  in  DATA_W  pre-shifted lui value.
REQ-014 memSize  in  2  load size: 0 byte, 1 half, 2 word, 3 dword.
REQ-015 memSigned  in  1  1 sign-extends, 0 zero-extends the load.
REQ-016 writeReg  in  REG_AW  destination register.
REQ-017 regWrite  in  1  instruction writes the register file.
REQ-018 data  out  DATA_W  registered writeback value.
REQ-019 wrReg  out  REG_AW  registered destination.
REQ-020 regWriteOut  out  1  registered, qualified write enable.
REQ-021 validOut  out  1  registered valid.
REQ-022 align_err  out  1  registered misaligned-load flag, one cycle per offending instruction.

Function
REQ-023 Latency SHALL be exactly one clk: inputs sampled at edge N appear on outputs after edge N.
REQ-024 Load extraction SHALL be big-endian: byte lane k (offset k) = DMresult bits [DATA_W-1-8k : DATA_W-8-8k]; half at offset k = lanes k,k+1; word at offset k = lanes k..k+3.
REQ-025 The extracted lane SHALL be extended to DATA_W by sign (memSigned=1) or zeros (memSigned=0); dword and (DATA_W=32) word SHALL pass DMresult unchanged.
REQ-026 memSize=3 with DATA_W=32 SHALL be treated as word.
REQ-027 Misaligned SHALL mean: half with offset bit 0 set; word with offset[1:0]!=0; dword with offset!=0 (DATA_W=64); misalignment is checked only when wbSel=1.
REQ-028 On a capture edge, align_err SHALL be set to in_valid & misaligned & ~flush; a misaligned load SHALL force regWriteOut=0 and data=0.
REQ-029 regWriteOut SHALL be in_valid & regWrite & (writeReg!=0) & ~misaligned; writes to register 0 are suppressed.
REQ-030 wrReg and data SHALL be captured regardless of in_valid; consumers qualify with validOut/regWriteOut.
REQ-031 stall=1, flush=0 SHALL hold every output register, align_err included.
REQ-032 flush=1 SHALL clear validOut, regWriteOut and align_err on the next edge, overriding stall; data and wrReg are then don't-care but SHALL be written to 0.
REQ-033 wbSel values SHALL be decoded fully; no value produces X.

Reset
REQ-034 rst_n=0 SHALL immediately, without a clock, force data=0, wrReg=0, regWriteOut=0, validOut=0, align_err=0.
REQ-035 Deassertion of rst_n mid-stream SHALL discard any instruction presented in the reset cycle; first capture occurs on the first rising edge with rst_n=1.

Verification
REQ-036 ALU path: wbSel=0, ALUresult=32'h00FF, in_valid=1, regWrite=1, writeReg=8 -> next edge data=32'h000000FF, wrReg=8, regWriteOut=1, validOut=1.
REQ-037 Signed byte: wbSel=1, memSize=0, memSigned=1, ALUresult=32'h10010001, DMresult=32'h12F45678 -> data=32'hFFFFFFF4; same with memSigned=0 -> 32'h000000F4.
REQ-038 Misaligned: wbSel=1, memSize=2, ALUresult=32'h10010006 -> align_err=1, regWriteOut=0, data=0 for exactly one cycle.
REQ-039 Register 0 / link: wbSel=2, linkAddr=32'h00400010, writeReg=0 -> data=32'h00400010, regWriteOut=0; writeReg=31 -> regWriteOut=1.
REQ-040 Stall then flush: capture ALUresult=32'h1234, hold stall=1 for 3 cycles -> outputs unchanged; assert flush with stall=1 -> validOut=0, regWriteOut=0, data=0 next edge.
REQ-041 Async reset: assert rst_n=0 between edges while validOut=1 -> all outputs 0 before the next clk edge; DATA_W=64 rerun of REQ-037 with offset 5 -> lane 5 extracted.
